// File: rtl/shift_register_256_ctrl_if.sv
// -----------------------------------------------------------------------------
// shift_register_256_ctrl_if
//
// Host-side bundle for the shift-register sequencer.
// It groups the command strobe, the status flags, and the two byte-wide
// valid/ready streams.
//
// Signals:
//   start, op, dir, abort  command strobe, opcode (0 LOAD / 1 READ),
//                          shift direction and cancel request
//   busy, done             sequencer status; done is a one-cycle pulse
//   in_data/in_valid/in_ready     load byte stream (host -> sequencer)
//   out_data/out_valid/out_ready  readback byte stream (sequencer -> host)
//
// Modports:
//   master  host / bus logic side
//   slave   sequencer side
// -----------------------------------------------------------------------------
interface shift_register_256_ctrl_if;

   logic       start;
   logic       op;
   logic       dir;
   logic       abort;
   logic       busy;
   logic       done;

   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;

   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;

   modport master (
      output start, op, dir, abort,
      output in_data, in_valid,
      output out_ready,
      input  busy, done,
      input  in_ready,
      input  out_data, out_valid
   );

   modport slave (
      input  start, op, dir, abort,
      input  in_data, in_valid,
      input  out_ready,
      output busy, done,
      output in_ready,
      output out_data, out_valid
   );

endinterface : shift_register_256_ctrl_if

// File: rtl/shift_register_256_ctrl.sv
// -----------------------------------------------------------------------------
// shift_register_256_ctrl
//
// Sequencer that owns the control pins of a LEN-bit serial-in/serial-out
// shift register.
//   LOAD: bytes taken from the input stream are shifted in LSB first,
//         8 register clocks per byte.
//   READ: the frame is shifted out and packed into bytes on the output
//         stream. The bit leaving dout is fed straight back into din, so a
//         complete READ rotates the register by LEN bits and leaves its
//         contents intact.
//
// Ports:
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   bus           host bundle (slave modport): start/op/dir/abort,
//                 busy/done, in_* load stream, out_* readback stream
//   sr_en         shift enable to the register
//   sr_din        serial data to the register
//   sr_shift_dir  direction to the register (0 = left, 1 = right)
//   sr_dout       serial data from the register
//
// Parameters:
//   LEN    frame length in bits; a multiple of 8 and at least 8
//   CNT_W  bit-counter width; 2**CNT_W must exceed LEN
// -----------------------------------------------------------------------------
module shift_register_256_ctrl #(
   parameter int LEN   = 256,
   parameter int CNT_W = 9
) (
   input  logic                      clk,
   input  logic                      rst_n,
   shift_register_256_ctrl_if.slave  bus,
   output logic                      sr_en,
   output logic                      sr_din,
   output logic                      sr_shift_dir,
   input  logic                      sr_dout
);

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      LOAD_WAIT  = 3'd1,
      LOAD_SHIFT = 3'd2,
      READ_SHIFT = 3'd3,
      READ_HOLD  = 3'd4,
      DONE       = 3'd5
   } state_t;

   localparam logic [CNT_W-1:0] LEN_C = CNT_W'(LEN);
   localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] cnt_inc;
   logic [7:0]       in_buf_q, in_buf_d;
   logic [7:0]       out_buf_q, out_buf_d;
   logic             dir_q, dir_d;
   logic             last_bit;

   // Registered outputs, all decoded from the next state so that they
   // change on the same edge as the state itself.
   logic             busy_q;
   logic             done_q;
   logic             in_ready_q;
   logic             out_valid_q;
   logic             sr_en_q;

   assign cnt_inc  = cnt_q + ONE_C;
   // The counter is a multiple of 8 at every byte boundary, so its low
   // three bits tell us when the current shift is the eighth of the byte.
   assign last_bit = (cnt_q[2:0] == 3'd7);

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      in_buf_d  = in_buf_q;
      out_buf_d = out_buf_q;
      dir_d     = dir_q;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               dir_d   = bus.dir;
               cnt_d   = '0;
               state_d = bus.op ? READ_SHIFT : LOAD_WAIT;
            end
         end

         LOAD_WAIT: begin
            if (bus.in_valid && in_ready_q) begin
               in_buf_d = bus.in_data;
               state_d  = LOAD_SHIFT;
            end
         end

         LOAD_SHIFT: begin
            // sr_din presents in_buf_q[0]; shifting right exposes the next
            // bit for the following register clock.
            in_buf_d = {1'b0, in_buf_q[7:1]};
            cnt_d    = cnt_inc;
            if (last_bit) begin
               state_d = (cnt_inc == LEN_C) ? DONE : LOAD_WAIT;
            end
         end

         READ_SHIFT: begin
            // sr_dout is sampled on the same edge that shifts the register,
            // so the captured bit is the one leaving before that shift.
            out_buf_d = {sr_dout, out_buf_q[7:1]};
            cnt_d     = cnt_inc;
            if (last_bit) begin
               state_d = READ_HOLD;
            end
         end

         READ_HOLD: begin
            if (bus.out_ready && out_valid_q) begin
               state_d = (cnt_q == LEN_C) ? DONE : READ_SHIFT;
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      // Cancel wins over every other transition; the register keeps its
      // partial contents and no done pulse is produced.
      if (bus.abort && (state_q != IDLE)) begin
         state_d = IDLE;
      end
   end

   // -------------------------------------------------------------------------
   // State, counter, direction and registered outputs
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         out_buf_q   <= '0;
         dir_q       <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         sr_en_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         out_buf_q   <= out_buf_d;
         dir_q       <= dir_d;
         busy_q      <= (state_d != IDLE);
         done_q      <= (state_d == DONE);
         in_ready_q  <= (state_d == LOAD_WAIT);
         out_valid_q <= (state_d == READ_HOLD);
         sr_en_q     <= (state_d == LOAD_SHIFT) || (state_d == READ_SHIFT);
      end
   end

   // Load byte buffer: pure data, only meaningful after a transfer.
   always_ff @(posedge clk) begin
      in_buf_q <= in_buf_d;
   end

   // -------------------------------------------------------------------------
   // Output drive
   // -------------------------------------------------------------------------
   // sr_din is combinational: the buffered load bit while loading, the
   // recirculated dout while reading, and 0 otherwise.
   always_comb begin
      sr_din = 1'b0;
      if (state_q == LOAD_SHIFT) begin
         sr_din = in_buf_q[0];
      end else if (state_q == READ_SHIFT) begin
         sr_din = sr_dout;
      end
   end

   assign sr_en         = sr_en_q;
   assign sr_shift_dir  = dir_q;

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_buf_q;

endmodule : shift_register_256_ctrl

// File: tb/tb_shift_register_256_ctrl.sv
module tb_shift_register_256_ctrl;

   localparam int LEN = 256;
   localparam int NB  = LEN / 8;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   shift_register_256_ctrl_if bus ();

   logic sr_en, sr_din, sr_shift_dir, sr_dout;

   shift_register_256_ctrl #(.LEN(LEN), .CNT_W(9)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .bus          (bus),
      .sr_en        (sr_en),
      .sr_din       (sr_din),
      .sr_shift_dir (sr_shift_dir),
      .sr_dout      (sr_dout)
   );

   // Behavioural 256-bit SISO register driven by the sequencer.
   logic [LEN-1:0] sr_q = '0;
   always @(posedge clk) begin
      if (sr_en) sr_q <= sr_shift_dir ? {sr_din, sr_q[LEN-1:1]} : {sr_q[LEN-2:0], sr_din};
   end
   assign sr_dout = sr_shift_dir ? sr_q[0] : sr_q[LEN-1];

   // Edge counters for sr_en cycles and done pulses.
   int en_cnt   = 0;
   int done_cnt = 0;
   always @(posedge clk) begin
      if (sr_en)    en_cnt   <= en_cnt + 1;
      if (bus.done) done_cnt <= done_cnt + 1;
   end

   int vectors     = 0;
   int miscompares = 0;

   logic [7:0] ld [NB];
   logic [7:0] rd [NB];

   int ld_done_edge, ld_xfers, ld_bad, ld_dir_bad;
   bit ld_aborted;
   int rd_done_edge, rd_beats, rd_bad;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic int bytes_bad();
      int n = 0;
      for (int i = 0; i < NB; i++) if (rd[i] !== ld[i]) n++;
      return n;
   endfunction

   // LOAD of ld[] with optional input gaps, abort at a given shift count,
   // and an optional start strobe issued while busy.
   task automatic run_load(input logic d, input int gap, input int abort_at, input bit poke);
      int b, w, e0;
      logic xf;
      ld_done_edge = -1; ld_xfers = 0; ld_bad = 0; ld_dir_bad = 0; ld_aborted = 0;
      b = 0; w = 0; e0 = en_cnt;
      bus.start = 1'b1; bus.op = 1'b0; bus.dir = d; bus.in_valid = 1'b0;
      tick();
      bus.start = 1'b0;
      for (int c = 1; c <= 2000; c++) begin
         if (gap == 0) begin
            bus.in_valid = (b < NB);
            if (b < NB) bus.in_data = ld[b];
         end else begin
            bus.in_valid = 1'b0;
            if (bus.in_ready) begin
               if (w > 0) w--;
               else if (b < NB) begin
                  bus.in_valid = 1'b1;
                  bus.in_data  = ld[b];
               end
            end
         end
         if (bus.in_ready && sr_en) ld_bad++;
         if (sr_shift_dir !== d) ld_dir_bad++;
         if (poke && c == 5) begin
            bus.start = 1'b1; bus.op = 1'b1; bus.dir = ~d;
         end else begin
            bus.start = 1'b0;
         end
         if (abort_at >= 0 && sr_en && (en_cnt - e0) == abort_at) bus.abort = 1'b1;
         xf = bus.in_valid && bus.in_ready;
         tick();
         if (xf) begin
            ld_xfers++; b++; w = gap;
         end
         if (bus.abort) begin
            bus.abort = 1'b0; ld_aborted = 1;
            break;
         end
         if (bus.done) begin
            ld_done_edge = c;
            break;
         end
      end
      bus.in_valid = 1'b0; bus.start = 1'b0; bus.dir = d;
   endtask

   // READ into rd[] with optional stall of stall_len cycles on one beat.
   task automatic run_read(input logic d, input int stall_beat, input int stall_len);
      int beat, s;
      logic [7:0] hold;
      logic hs;
      rd_done_edge = -1; rd_beats = 0; rd_bad = 0;
      beat = 0; s = 0; hold = '0;
      for (int i = 0; i < NB; i++) rd[i] = 8'hxx;
      bus.start = 1'b1; bus.op = 1'b1; bus.dir = d; bus.out_ready = 1'b1;
      tick();
      bus.start = 1'b0;
      for (int c = 1; c <= 2000; c++) begin
         bus.out_ready = 1'b1;
         if (bus.out_valid && sr_en) rd_bad++;
         if (bus.out_valid && beat == stall_beat && s < stall_len) begin
            if (s == 0) hold = bus.out_data;
            else if (bus.out_data !== hold) rd_bad++;
            if (sr_en) rd_bad++;
            bus.out_ready = 1'b0;
            s++;
         end
         hs = bus.out_valid && bus.out_ready;
         if (hs) begin
            if (beat < NB) rd[beat] = bus.out_data;
            beat++;
         end
         tick();
         if (bus.done) begin
            rd_done_edge = c;
            break;
         end
      end
      rd_beats = beat;
      bus.out_ready = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int e0, d0;
      logic [LEN-1:0] snap;

      bus.start = 1'b0; bus.op = 1'b0; bus.dir = 1'b0; bus.abort = 1'b0;
      bus.in_data = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);

      // Reset state
      chk("rst_busy",      bus.busy,      0);
      chk("rst_done",      bus.done,      0);
      chk("rst_in_ready",  bus.in_ready,  0);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_sr_en",     sr_en,         0);
      chk("rst_sr_din",    sr_din,        0);
      chk("rst_sr_dir",    sr_shift_dir,  0);
      chk("rst_out_data",  bus.out_data,  0);
      rst_n = 1'b1;
      tick();

      // Abort while idle has no effect
      bus.abort = 1'b1; tick(); bus.abort = 1'b0;
      chk("idle_abort_busy", bus.busy, 0);

      // Full load, in_valid held high, bytes 0x00..0x1F, dir left
      for (int i = 0; i < NB; i++) ld[i] = 8'(i);
      e0 = en_cnt; d0 = done_cnt;
      run_load(1'b0, 0, -1, 0);
      chk("load_done_edge", ld_done_edge, 288);
      chk("load_xfers",     ld_xfers,     32);
      chk("load_wait_en",   ld_bad,       0);
      chk("load_dir",       ld_dir_bad,   0);
      tick();
      chk("load_en_cycles", en_cnt - e0,  256);
      chk("load_done_cnt",  done_cnt - d0, 1);
      chk("load_busy_after", bus.busy,    0);
      chk("load_first_bit", sr_q[LEN-1],  0);
      chk("load_msb_byte",  sr_q[7:0],    8'hF8);

      // Round trip read, then a second read for recirculation
      for (int k = 0; k < 2; k++) begin
         snap = sr_q; e0 = en_cnt; d0 = done_cnt;
         run_read(1'b0, -1, 0);
         tick();
         chk("rd_done_edge", rd_done_edge, 288);
         chk("rd_beats",     rd_beats,     32);
         chk("rd_bytes_bad", bytes_bad(),  0);
         chk("rd_byte0",     rd[0],        8'h00);
         chk("rd_byte31",    rd[31],       8'h1F);
         chk("rd_en_cycles", en_cnt - e0,  256);
         chk("rd_done_cnt",  done_cnt - d0, 1);
         chk("rd_preserved", (sr_q === snap), 1);
         chk("rd_protocol",  rd_bad,       0);
      end

      // Output backpressure: 20-cycle stall on beat 5
      e0 = en_cnt;
      run_read(1'b0, 5, 20);
      tick();
      chk("bp_done_edge", rd_done_edge, 308);
      chk("bp_stall",     rd_bad,       0);
      chk("bp_bytes_bad", bytes_bad(),  0);
      chk("bp_byte5",     rd[5],        8'h05);
      chk("bp_en_cycles", en_cnt - e0,  256);

      // Input gaps of 7 cycles, dir right, pattern A5/3C
      for (int i = 0; i < NB; i++) ld[i] = (i % 2 == 0) ? 8'hA5 : 8'h3C;
      e0 = en_cnt;
      run_load(1'b1, 7, -1, 0);
      tick();
      chk("gap_done_edge", ld_done_edge, 505);
      chk("gap_wait_en",   ld_bad,       0);
      chk("gap_dir",       ld_dir_bad,   0);
      chk("gap_en_cycles", en_cnt - e0,  256);
      run_read(1'b1, -1, 0);
      tick();
      chk("gap_rd_edge",   rd_done_edge, 288);
      chk("gap_rd_bad",    bytes_bad(),  0);
      chk("gap_rd_byte1",  rd[1],        8'h3C);

      // Abort during LOAD_SHIFT at bit 100
      for (int i = 0; i < NB; i++) ld[i] = 8'hFF;
      e0 = en_cnt; d0 = done_cnt;
      run_load(1'b0, 0, 100, 0);
      chk("ab_taken",     ld_aborted,   1);
      chk("ab_busy",      bus.busy,     0);
      chk("ab_sr_en",     sr_en,        0);
      chk("ab_in_ready",  bus.in_ready, 0);
      chk("ab_en_cycles", en_cnt - e0,  101);
      repeat (3) tick();
      chk("ab_no_done",   done_cnt - d0, 0);
      for (int i = 0; i < NB; i++) ld[i] = 8'(8'h47 * i + 8'h11);
      e0 = en_cnt;
      run_load(1'b0, 0, -1, 0);
      tick();
      chk("ab_reload_edge", ld_done_edge, 288);
      chk("ab_reload_en",   en_cnt - e0,  256);
      run_read(1'b0, -1, 0);
      tick();
      chk("ab_reload_rd",   bytes_bad(),  0);
      chk("ab_reload_b2",   rd[2],        8'h9F);

      // Asynchronous reset in READ_HOLD
      bus.start = 1'b1; bus.op = 1'b1; bus.dir = 1'b0; bus.out_ready = 1'b0;
      tick();
      bus.start = 1'b0;
      for (int c = 0; c < 50 && !bus.out_valid; c++) tick();
      chk("rr_hold_reached", bus.out_valid, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("rr_out_valid", bus.out_valid, 0);
      chk("rr_busy",      bus.busy,      0);
      chk("rr_sr_en",     sr_en,         0);
      chk("rr_out_data",  bus.out_data,  0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // start while busy is ignored
      for (int i = 0; i < NB; i++) ld[i] = 8'(8'hE1 ^ (8'(i) << 2));
      e0 = en_cnt;
      run_load(1'b0, 0, -1, 1);
      tick();
      chk("sb_done_edge", ld_done_edge, 288);
      chk("sb_dir",       ld_dir_bad,   0);
      chk("sb_en_cycles", en_cnt - e0,  256);
      run_read(1'b0, -1, 0);
      tick();
      chk("sb_rd_bad",    bytes_bad(),  0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_shift_register_256_ctrl

// File: doc/shift_register_256_ctrl.md
Name: shift_register_256_ctrl

Overview:
Sequencer that owns the control pins of the 256-bit SISO shift register (en, din, shift_dir, dout). It bursts a LEN-bit frame into the register from a byte-wide valid/ready input stream, or reads the frame back out as bytes on a valid/ready output stream. During readback it recirculates dout into din, so the stored contents are preserved. It sits between the bus/host logic and the shift register, and is the only driver of the register's control pins.

Parameters:
LEN, 256, frame length in bits; must be a multiple of 8 and ≥ 8
CNT_W, 9, bit-counter width; must satisfy 2**CNT_W > LEN

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle command strobe; sampled only in IDLE
op  in  1  command sampled with start: 0 = LOAD, 1 = READ
dir  in  1  shift direction sampled with start (0 = left, 1 = right)
abort  in  1  synchronous cancel of the current operation
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse on normal completion
in_data  in  8  load byte, shifted LSB first
in_valid  in  1  load byte valid
in_ready  out  1  controller accepts a load byte
out_data  out  8  readback byte; first bit out is bit 0
out_valid  out  1  readback byte valid
out_ready  in  1  consumer accepts a readback byte
sr_en  out  1  to shift register en
sr_din  out  1  to shift register din
sr_shift_dir  out  1  to shift register shift_dir
sr_dout  in  1  from shift register dout

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy, done, in_ready, out_valid, sr_en, sr_din, sr_shift_dir = 0; out_data = 0; bit counter = 0.
- States: IDLE, LOAD_WAIT, LOAD_SHIFT, READ_SHIFT, READ_HOLD, DONE.
- IDLE: when start=1, latch op and dir into sr_shift_dir and clear the bit counter.
  - op=0 goes to LOAD_WAIT; op=1 goes to READ_SHIFT.
  - sr_shift_dir holds constant for the whole operation.
- LOAD_WAIT: in_ready=1 and sr_en=0, so the register holds. A transfer (in_valid & in_ready) captures in_data into the byte buffer and moves to LOAD_SHIFT.
- LOAD_SHIFT: exactly 8 cycles with sr_en=1.
  - Each cycle: sr_din = buffer bit 0 (combinational from the buffer), buffer shifts right, counter +1.
  - After the 8th bit: counter == LEN goes to DONE; otherwise back to LOAD_WAIT.
  - in_ready=0 throughout. Throughput is 9 cycles per byte minimum.
- READ_SHIFT: exactly 8 cycles with sr_en=1 and sr_din = sr_dout (recirculate).
  - Capture happens on the same edge as the shift: out buffer <= {sr_dout, buffer[7:1]}. The value captured is dout before that shift.
  - Counter +1 per cycle. After the 8th bit go to READ_HOLD.
- READ_HOLD: sr_en=0, out_valid=1, out_data = buffer, held stable until out_ready.
  - On out_valid & out_ready: counter == LEN goes to DONE; otherwise back to READ_SHIFT.
- DONE: done=1 for exactly one cycle, busy still 1, then IDLE.
- abort=1 in any non-IDLE state:
  - Next state is IDLE; sr_en and out_valid drop on that edge; no done pulse.
  - The register keeps whatever partial contents it has. abort in IDLE is ignored.
- start while busy is ignored. abort has priority over all other transitions.
- Ordering guarantee: after a full LOAD, a READ with the same dir returns the bytes in load order, bit-identical. A full READ rotates the register by LEN bits, so the contents are unchanged.
- sr_en is never high outside LOAD_SHIFT and READ_SHIFT. The total number of sr_en cycles per completed operation is exactly LEN.

Test Plan:
- Load, in_valid held high: reset, start op=0 dir=0, bytes 0x00..0x1F → in_ready pulses 32 times, sr_en high for exactly 256 cycles, done pulses once in the cycle after the 288th edge following the start edge; busy=0 afterwards.
- Round trip: after the load above, start op=1 dir=0 with out_ready=1 → 32 out_valid beats carrying 0x00..0x1F in order, then done. A second READ returns the identical sequence, confirming recirculation.
- Output backpressure: READ with out_ready low for 20 cycles on beat 5 → out_valid and out_data stay stable and sr_en=0 throughout the stall. Data remains correct and the total sr_en count is still 256.
- Input gaps: LOAD with in_valid low for 7 cycles between bytes → no sr_en during gaps. A subsequent READ returns the exact loaded data (pattern 0xA5, 0x3C repeated).
- Abort: abort asserted in LOAD_SHIFT at bit 100 → IDLE next cycle, sr_en=0, no done. A new start op=0 is accepted immediately and completes normally.
- Reset mid-READ: rst_n low during READ_HOLD → all outputs 0 asynchronously, out_valid=0, IDLE. start is ignored while busy in a separate run.
